// File: rtl/apb_timer_pkg.sv
// Shared constants for the multi-channel APB timer: register offsets,
// TCR/TSR bit positions and prescaler divider encodings.
package apb_timer_pkg;

    localparam logic [1:0] OFS_TDR  = 2'd0;
    localparam logic [1:0] OFS_TCR  = 2'd1;
    localparam logic [1:0] OFS_TSR  = 2'd2;
    localparam logic [1:0] OFS_TCNT = 2'd3;

    // TCR storage holds bits [6:0]; LOAD (bit 7) is a strobe and never stored.
    localparam int TCR_W      = 7;
    localparam int TCR_CKS_LO = 0;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_OVF_IE = 2;
    localparam int TCR_UDF_IE = 3;
    localparam int TCR_EN     = 4;
    localparam int TCR_DN     = 5;
    localparam int TCR_ARL    = 6;
    localparam int TCR_LOAD   = 7;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    // Prescaler bits that must all be ones for a tick at the given divider.
    function automatic logic [3:0] cks_mask(input logic [1:0] cks);
        logic [3:0] mask;
        case (cks)
            CKS_DIV2:  mask = 4'b0001;
            CKS_DIV4:  mask = 4'b0011;
            CKS_DIV8:  mask = 4'b0111;
            CKS_DIV16: mask = 4'b1111;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/apb_timer_ch.sv
// One timer channel: TDR/TCR/TSR/TCNT registers, 4-bit prescaler,
// up/down counter with optional auto-reload, sticky flags and level irq.
module apb_timer_ch
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             wr_en,
    input  logic [1:0]       ofs,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    output logic             irq
);

    logic [CNT_W-1:0] tdr_r;
    logic [CNT_W-1:0] tcnt_r;
    logic [TCR_W-1:0] tcr_r;
    logic [3:0]       presc_r;
    logic             ovf_r;
    logic             udf_r;

    logic             wr_tdr_s;
    logic             wr_tcr_s;
    logic             wr_tsr_s;
    logic             load_s;
    logic             en_s;
    logic             dn_s;
    logic             arl_s;
    logic [3:0]       mask_s;
    logic             tick_s;
    logic [CNT_W-1:0] tcnt_nxt_s;
    logic             ovf_set_s;
    logic             udf_set_s;
    logic [CNT_W-1:0] rdata_s;

    assign wr_tdr_s = wr_en & (ofs == OFS_TDR);
    assign wr_tcr_s = wr_en & (ofs == OFS_TCR);
    assign wr_tsr_s = wr_en & (ofs == OFS_TSR);
    assign load_s   = wr_tcr_s & wdata[TCR_LOAD];

    assign en_s   = tcr_r[TCR_EN];
    assign dn_s   = tcr_r[TCR_DN];
    assign arl_s  = tcr_r[TCR_ARL];
    assign mask_s = cks_mask(tcr_r[TCR_CKS_HI:TCR_CKS_LO]);
    assign tick_s = en_s & ((presc_r & mask_s) == mask_s);

    // Counter next value and flag set conditions; LOAD overrides a coincident tick.
    always_comb begin
        tcnt_nxt_s = tcnt_r;
        ovf_set_s  = 1'b0;
        udf_set_s  = 1'b0;
        if (load_s) begin
            tcnt_nxt_s = tdr_r;
        end else if (tick_s) begin
            if (dn_s) begin
                if (tcnt_r == {CNT_W{1'b0}}) begin
                    tcnt_nxt_s = arl_s ? tdr_r : {CNT_W{1'b1}};
                    udf_set_s  = 1'b1;
                end else begin
                    tcnt_nxt_s = tcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (tcnt_r == {CNT_W{1'b1}}) begin
                    tcnt_nxt_s = arl_s ? tdr_r : {CNT_W{1'b0}};
                    ovf_set_s  = 1'b1;
                end else begin
                    tcnt_nxt_s = tcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            tcnt_nxt_s = tcnt_r;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tdr_r <= {CNT_W{1'b0}};
            tcr_r <= {TCR_W{1'b0}};
        end else begin
            if (wr_tdr_s) begin
                tdr_r <= wdata;
            end
            if (wr_tcr_s) begin
                tcr_r <= wdata[TCR_W-1:0];
            end
        end
    end

    // Prescaler runs only while enabled so the first tick lands a full period after EN.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            presc_r <= 4'd0;
        end else if (!en_s) begin
            presc_r <= 4'd0;
        end else begin
            presc_r <= presc_r + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tcnt_r <= {CNT_W{1'b0}};
        end else begin
            tcnt_r <= tcnt_nxt_s;
        end
    end

    // Sticky flags: a new event beats a simultaneous write-one-to-clear.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_set_s | (ovf_r & ~(wr_tsr_s & wdata[TSR_OVF]));
            udf_r <= udf_set_s | (udf_r & ~(wr_tsr_s & wdata[TSR_UDF]));
        end
    end

    // Read-back view of the selected register.
    always_comb begin
        rdata_s = {CNT_W{1'b0}};
        case (ofs)
            OFS_TDR:  rdata_s = tdr_r;
            OFS_TCR:  rdata_s = {{(CNT_W-TCR_W){1'b0}}, tcr_r};
            OFS_TSR:  rdata_s = {{(CNT_W-2){1'b0}}, udf_r, ovf_r};
            OFS_TCNT: rdata_s = tcnt_r;
            default:  rdata_s = {CNT_W{1'b0}};
        endcase
    end

    assign rdata = rdata_s;
    assign irq   = (ovf_r & tcr_r[TCR_OVF_IE]) | (udf_r & tcr_r[TCR_UDF_IE]);

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer top: address decode, channel select, read mux,
// error response for out-of-range channels, and N_CH channel instances.
module apb_timer_mc
    import apb_timer_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [CNT_W-1:0]  pwdata,
    output logic [CNT_W-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [N_CH-1:0]   irq
);

    logic [31:0]      ch_idx_s;
    logic [1:0]       ofs_s;
    logic             ch_valid_s;
    logic             acc_s;
    logic             wr_s;
    logic             rd_s;
    logic [N_CH-1:0]  ch_wr_s;
    logic [N_CH-1:0]  ch_rd_s;
    logic [CNT_W-1:0] ch_rdata_s [N_CH];
    logic [CNT_W-1:0] prdata_s;

    // Index is widened so N_CH = 2^k still compares correctly against a k-bit field.
    assign ch_idx_s   = 32'(paddr[ADDR_W-1:2]);
    assign ofs_s      = paddr[1:0];
    assign ch_valid_s = (ch_idx_s < 32'(N_CH));
    assign acc_s      = psel & penable;
    assign wr_s       = acc_s & pwrite & ch_valid_s;
    assign rd_s       = acc_s & ~pwrite & ch_valid_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch_wr_s[g] = wr_s & (ch_idx_s == 32'(g));
        assign ch_rd_s[g] = rd_s & (ch_idx_s == 32'(g));

        apb_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .pclk   (pclk),
            .preset (preset),
            .wr_en  (ch_wr_s[g]),
            .ofs    (ofs_s),
            .wdata  (pwdata),
            .rdata  (ch_rdata_s[g]),
            .irq    (irq[g])
        );
    end

    // One-hot AND-OR read mux; zero unless a valid read is in its access phase.
    always_comb begin
        prdata_s = {CNT_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            prdata_s = prdata_s | (ch_rdata_s[i] & {CNT_W{ch_rd_s[i]}});
        end
    end

    assign prdata  = prdata_s;
    assign pready  = 1'b1;
    assign pslverr = acc_s & ~ch_valid_s;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc (N_CH=4, CNT_W=8): directed scenarios
// plus random APB traffic, all checked against a cycle-level behavioural model.
module tb_apb_timer_mc;

    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int AW   = 8;
    localparam int MAXV = 255;

    logic          pclk;
    logic          preset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [CW-1:0] pwdata;
    logic [CW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [NC-1:0] irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state per channel
    int m_tdr  [NC];
    int m_tcr  [NC];
    int m_cnt  [NC];
    int m_ecnt [NC];
    bit m_ovf  [NC];
    bit m_udf  [NC];

    apb_timer_mc #(.N_CH(NC), .CNT_W(CW), .ADDR_W(AW)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Model: ecnt = enabled clock edges since EN rose; a tick lands every div-th one.
    always @(posedge pclk or posedge preset) begin : model
        int  cnt, div, ecnt, ofs;
        bit  tick, mine, ld, so, su, dn, arl;
        if (preset) begin
            for (int c = 0; c < NC; c++) begin
                m_tdr[c]  <= 0;
                m_tcr[c]  <= 0;
                m_cnt[c]  <= 0;
                m_ecnt[c] <= 0;
                m_ovf[c]  <= 1'b0;
                m_udf[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                cnt  = m_cnt[c];
                div  = 2 << (m_tcr[c] & 3);
                tick = 1'b0;
                if (m_tcr[c][4]) begin
                    ecnt = m_ecnt[c] + 1;
                    tick = ((ecnt % div) == 0);
                end else begin
                    ecnt = 0;
                end
                dn   = m_tcr[c][5];
                arl  = m_tcr[c][6];
                mine = psel && penable && pwrite && (int'(paddr >> 2) == c);
                ofs  = int'(paddr & 8'h03);
                ld   = mine && (ofs == 1) && pwdata[7];
                so   = 1'b0;
                su   = 1'b0;
                if (ld) begin
                    cnt = m_tdr[c];
                end else if (tick) begin
                    if (!dn) begin
                        if (cnt == MAXV) begin
                            cnt = arl ? m_tdr[c] : 0;
                            so  = 1'b1;
                        end else begin
                            cnt = cnt + 1;
                        end
                    end else begin
                        if (cnt == 0) begin
                            cnt = arl ? m_tdr[c] : MAXV;
                            su  = 1'b1;
                        end else begin
                            cnt = cnt - 1;
                        end
                    end
                end
                m_cnt[c]  <= cnt;
                m_ecnt[c] <= ecnt;
                m_ovf[c]  <= so || (m_ovf[c] && !(mine && ofs == 2 && pwdata[0]));
                m_udf[c]  <= su || (m_udf[c] && !(mine && ofs == 2 && pwdata[1]));
                if (mine && ofs == 0) m_tdr[c] <= int'(pwdata);
                if (mine && ofs == 1) m_tcr[c] <= int'(pwdata) & 32'h7F;
            end
        end
    end

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        int c = int'(a >> 2);
        int o = int'(a & 8'h03);
        if (c >= NC) return 8'h00;
        case (o)
            0:       return 8'(m_tdr[c]);
            1:       return 8'(m_tcr[c]);
            2:       return {6'd0, m_udf[c], m_ovf[c]};
            default: return 8'(m_cnt[c]);
        endcase
    endfunction

    function automatic logic [3:0] exp_irq();
        logic [3:0] r = 4'd0;
        for (int c = 0; c < NC; c++)
            r[c] = (m_ovf[c] && m_tcr[c][2]) || (m_udf[c] && m_tcr[c][3]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apb_rd(input string tag, input logic [7:0] addr, output logic [7:0] d, output logic e);
        logic [7:0] xd;
        logic       xe;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        d  = prdata;
        e  = pslverr;
        xd = exp_read(addr);
        xe = (int'(addr >> 2) >= NC);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        chk(tag, 32'(d), 32'(xd));
        chk({tag, "_err"}, 32'(e), 32'(xe));
    endtask

    task automatic apb_wr(input string tag, input logic [7:0] addr, input logic [7:0] data, output logic e);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        e = pslverr;
        chk({tag, "_err"}, 32'(e), 32'(int'(addr >> 2) >= NC));
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] d;
        logic       e;
        bit         found;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;
        repeat (3) @(negedge pclk);
        preset = 1'b0;

        // Reset state of every register
        chk("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 16; a++) begin
            apb_rd("rst_rd", 8'(a), d, e);
            chk("rst_zero", 32'(d), 32'h0);
        end

        // ch0: up count, div 2, overflow at 512 cycles
        apb_wr("c0_tcr", 8'h01, 8'h10, e);
        repeat (508) @(negedge pclk);
        apb_rd("c0_tsr510", 8'h02, d, e);
        chk("c0_tsr510_c", 32'(d), 32'h00);
        apb_rd("c0_cnt513", 8'h03, d, e);
        chk("c0_cnt513_c", 32'(d), 32'h00);
        apb_rd("c0_tsr516", 8'h02, d, e);
        chk("c0_tsr516_c", 32'(d), 32'h01);
        apb_wr("c0_dn", 8'h01, 8'h30, e);
        repeat (40) @(negedge pclk);
        apb_rd("c0_tsr_udf", 8'h02, d, e);
        chk("c0_tsr_udf_c", 32'(d), 32'h03);

        // ch1: load + count down
        apb_wr("c1_tdr", 8'h04, 8'h05, e);
        apb_wr("c1_tcr", 8'h05, 8'hB0, e);
        apb_rd("c1_tcr_rd", 8'h05, d, e);
        chk("c1_tcr_c", 32'(d), 32'h30);
        repeat (6) @(negedge pclk);
        apb_rd("c1_cnt0", 8'h07, d, e);
        chk("c1_cnt0_c", 32'(d), 32'h00);
        apb_rd("c1_tsr", 8'h06, d, e);
        chk("c1_tsr_c", 32'(d), 32'h02);

        // ch2: auto-reload up count with overflow irq
        apb_wr("c2_tdr", 8'h08, 8'hF0, e);
        apb_wr("c2_tcr", 8'h09, 8'hD4, e);
        repeat (31) @(negedge pclk);
        apb_rd("c2_tsr", 8'h0A, d, e);
        chk("c2_tsr_c", 32'(d), 32'h01);
        chk("c2_irq_set", 32'(irq[2]), 32'h1);
        chk("c2_irq_m", 32'(irq), 32'(exp_irq()));
        apb_wr("c2_w1c", 8'h0A, 8'h01, e);
        chk("c2_irq_clr", 32'(irq[2]), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge pclk);
            if (m_cnt[2] == 8'hFE) found = 1'b1;
        end
        chk("c2_poll", 32'(found), 32'h1);
        @(negedge pclk);
        apb_wr("c2_collide", 8'h0A, 8'h01, e);
        apb_rd("c2_tsr_coll", 8'h0A, d, e);
        chk("c2_tsr_coll_c", 32'(d), 32'h01);

        // Out-of-range channel and read-only TCNT
        apb_wr("bad_wr", 8'h10, 8'hAB, e);
        chk("bad_wr_c", 32'(e), 32'h1);
        apb_rd("bad_rd", 8'h10, d, e);
        chk("bad_rd_d", 32'(d), 32'h00);
        chk("bad_rd_e", 32'(e), 32'h1);
        apb_rd("bad_c0_tdr", 8'h00, d, e);
        apb_wr("tcnt_wr", 8'h0F, 8'h55, e);
        chk("tcnt_wr_c", 32'(e), 32'h0);
        apb_rd("tcnt_rd", 8'h0F, d, e);
        chk("tcnt_rd_c", 32'(d), 32'h00);

        // Random traffic against the model
        for (int i = 0; i < 120; i++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 23));
            if ($urandom_range(0, 1) == 1)
                apb_wr("rnd_wr", a, 8'($urandom_range(0, 255)), e);
            else
                apb_rd("rnd_rd", a, d, e);
            repeat ($urandom_range(0, 5)) @(negedge pclk);
            chk("rnd_irq", 32'(irq), 32'(exp_irq()));
        end

        // Asynchronous reset mid-count
        apb_wr("r_tcr", 8'h01, 8'h10, e);
        repeat (10) @(negedge pclk);
        preset = 1'b1;
        #1;
        chk("r_irq", 32'(irq), 32'h0);
        apb_rd("r_cnt", 8'h03, d, e);
        chk("r_cnt_c", 32'(d), 32'h00);
        apb_rd("r_tcr_rd", 8'h01, d, e);
        chk("r_tcr_c", 32'(d), 32'h00);
        apb_rd("r_tsr", 8'h02, d, e);
        chk("r_tsr_c", 32'(d), 32'h00);
        @(negedge pclk);
        preset = 1'b0;
        repeat (20) @(negedge pclk);
        apb_rd("r_cnt_after", 8'h03, d, e);
        chk("r_cnt_after_c", 32'(d), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
